// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : ID-stage instruction fields in, pipeline control bundle out.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 4,
    parameter int RA_W    = 5
) ();
    logic               id_valid;
    logic [OP_W-1:0]    id_op;
    logic [FUNCT_W-1:0] id_funct;
    logic [RA_W-1:0]    id_rs;
    logic [RA_W-1:0]    id_rt;
    logic [RA_W-1:0]    id_rd;
    logic               ex_zero;

    logic               pc_write;
    logic               if_id_write;
    logic               if_id_flush;
    logic               id_jump;
    logic               ex_branch_taken;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               ex_alu_src;
    logic [FUNCT_W-1:0] ex_funct;
    logic [RA_W-1:0]    ex_dst;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic               mem_read;
    logic               mem_write;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic [RA_W-1:0]    wb_dst;
    logic               illegal_op;

    modport master (
        output id_valid, id_op, id_funct, id_rs, id_rt, id_rd, ex_zero,
        input  pc_write, if_id_write, if_id_flush, id_jump, ex_branch_taken,
               ex_alu_op, ex_alu_src, ex_funct, ex_dst, fwd_a, fwd_b,
               mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst, illegal_op
    );

    modport slave (
        input  id_valid, id_op, id_funct, id_rs, id_rt, id_rd, ex_zero,
        output pc_write, if_id_write, if_id_flush, id_jump, ex_branch_taken,
               ex_alu_op, ex_alu_src, ex_funct, ex_dst, fwd_a, fwd_b,
               mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : 5-stage MIPS control: decode, ID/EX..MEM/WB control pipe,
//            load-use stall, jump/branch flush and EX forwarding selects.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 4,
    parameter int RA_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam logic [OP_W-1:0] c_op_lw   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] c_op_sw   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] c_op_rtyp = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] c_op_imm  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] c_op_beq  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] c_op_j    = OP_W'(6'b000010);

    // ID decode
    logic               w_wr_raw, w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg;
    logic               w_alu_src, w_branch, w_jump, w_reads_rt, w_illegal, w_legal;
    logic [ALUOP_W-1:0] w_alu_op;
    logic [RA_W-1:0]    w_dst;
    logic               w_taken, w_load_use, w_stall, w_bubble;
    logic [1:0]         w_fwd_a, w_fwd_b;

    // ID/EX
    logic               r_ex_reg_write, r_ex_mem_read, r_ex_mem_write, r_ex_mem_to_reg;
    logic               r_ex_alu_src, r_ex_branch, r_ex_illegal;
    logic [ALUOP_W-1:0] r_ex_alu_op;
    logic [FUNCT_W-1:0] r_ex_funct;
    logic [RA_W-1:0]    r_ex_dst, r_ex_rs, r_ex_rt;
    // EX/MEM and MEM/WB
    logic               r_mem_reg_write, r_mem_mem_read, r_mem_mem_write, r_mem_mem_to_reg;
    logic [RA_W-1:0]    r_mem_dst;
    logic               r_wb_reg_write, r_wb_mem_to_reg;
    logic [RA_W-1:0]    r_wb_dst;

    always_comb begin
        w_alu_op     = '0;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_wr_raw     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_reads_rt   = 1'b0;
        w_illegal    = 1'b0;
        w_legal      = 1'b0;
        w_dst        = '0;
        if (bus.id_valid) begin
            case (bus.id_op)
                c_op_lw: begin
                    w_alu_op = ALUOP_W'(4'b0000); w_alu_src = 1'b1; w_mem_read = 1'b1;
                    w_wr_raw = 1'b1; w_mem_to_reg = 1'b1; w_dst = bus.id_rt; w_legal = 1'b1;
                end
                c_op_sw: begin
                    w_alu_op = ALUOP_W'(4'b0001); w_alu_src = 1'b1; w_mem_write = 1'b1;
                    w_legal = 1'b1;
                end
                c_op_rtyp: begin
                    w_alu_op = ALUOP_W'(4'b0010); w_wr_raw = 1'b1; w_dst = bus.id_rd;
                    w_reads_rt = 1'b1; w_legal = 1'b1;
                end
                c_op_imm: begin
                    w_alu_op = ALUOP_W'(4'b0011); w_alu_src = 1'b1; w_wr_raw = 1'b1;
                    w_dst = bus.id_rt; w_legal = 1'b1;
                end
                c_op_beq: begin
                    w_alu_op = ALUOP_W'(4'b0100); w_branch = 1'b1; w_reads_rt = 1'b1;
                    w_legal = 1'b1;
                end
                c_op_j:  w_jump    = 1'b1;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    // $0 is hard-wired, so a write to it is dropped here rather than downstream
    assign w_reg_write = w_wr_raw && (w_dst != '0);

    assign w_taken    = r_ex_branch & bus.ex_zero;
    assign w_load_use = r_ex_mem_read && (r_ex_dst != '0) &&
                        ((r_ex_dst == bus.id_rs) || (w_reads_rt && (r_ex_dst == bus.id_rt)));
    assign w_stall    = w_load_use & ~w_taken;
    assign w_bubble   = w_taken | w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_reg_write   <= 1'b0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_mem_to_reg  <= 1'b0;
            r_ex_alu_src     <= 1'b0;
            r_ex_branch      <= 1'b0;
            r_ex_illegal     <= 1'b0;
            r_ex_alu_op      <= '0;
            r_ex_funct       <= '0;
            r_ex_dst         <= '0;
            r_ex_rs          <= '0;
            r_ex_rt          <= '0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_dst        <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_dst         <= '0;
        end else begin
            r_ex_reg_write   <= w_reg_write  & ~w_bubble;
            r_ex_mem_read    <= w_mem_read   & ~w_bubble;
            r_ex_mem_write   <= w_mem_write  & ~w_bubble;
            r_ex_mem_to_reg  <= w_mem_to_reg & ~w_bubble;
            r_ex_alu_src     <= w_alu_src    & ~w_bubble;
            r_ex_branch      <= w_branch     & ~w_bubble;
            r_ex_illegal     <= w_illegal    & ~w_bubble;
            r_ex_alu_op      <= w_bubble ? '0 : w_alu_op;
            r_ex_dst         <= w_bubble ? '0 : w_dst;
            // jumps and illegal ops travel as full NOPs, operand fields included
            r_ex_funct       <= (w_legal && !w_bubble) ? bus.id_funct : '0;
            r_ex_rs          <= (w_legal && !w_bubble) ? bus.id_rs    : '0;
            r_ex_rt          <= (w_legal && !w_bubble) ? bus.id_rt    : '0;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_mem_read   <= r_ex_mem_read;
            r_mem_mem_write  <= r_ex_mem_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_dst        <= r_ex_dst;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_dst         <= r_mem_dst;
        end
    end

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_mem_reg_write && (r_mem_dst != '0) && (r_mem_dst == r_ex_rs))
            w_fwd_a = 2'b10;
        else if (r_wb_reg_write && (r_wb_dst != '0) && (r_wb_dst == r_ex_rs))
            w_fwd_a = 2'b01;
        if (r_mem_reg_write && (r_mem_dst != '0) && (r_mem_dst == r_ex_rt))
            w_fwd_b = 2'b10;
        else if (r_wb_reg_write && (r_wb_dst != '0) && (r_wb_dst == r_ex_rt))
            w_fwd_b = 2'b01;
    end

    assign bus.pc_write        = ~w_stall;
    assign bus.if_id_write     = ~w_stall;
    assign bus.id_jump         = w_jump & ~w_bubble & ~rst;
    assign bus.if_id_flush     = w_taken | (w_jump & ~w_bubble & ~rst);
    assign bus.ex_branch_taken = w_taken;
    assign bus.ex_alu_op       = r_ex_alu_op;
    assign bus.ex_alu_src      = r_ex_alu_src;
    assign bus.ex_funct        = r_ex_funct;
    assign bus.ex_dst          = r_ex_dst;
    assign bus.fwd_a           = w_fwd_a;
    assign bus.fwd_b           = w_fwd_b;
    assign bus.mem_read        = r_mem_mem_read;
    assign bus.mem_write       = r_mem_mem_write;
    assign bus.wb_reg_write    = r_wb_reg_write;
    assign bus.wb_mem_to_reg   = r_wb_mem_to_reg;
    assign bus.wb_dst          = r_wb_dst;
    assign bus.illegal_op      = r_ex_illegal;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Directed plus random bench for pipe_ctrl_unit against a stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;
    localparam bit [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam bit [5:0] OP_IMM = 6'b000001, OP_BEQ = 6'b000100, OP_J = 6'b000010;

    typedef struct packed {
        bit       rw, mr, mw, m2r, src, br, ill;
        bit [3:0] aluop;
        bit [5:0] funct;
        bit [4:0] dst, rs, rt;
    } ins_t;

    logic clk = 1'b0;
    logic rst;
    int   checks, failures;

    pipe_ctrl_if #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(4), .RA_W(5)) bus ();
    pipe_ctrl_unit #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(4), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    ins_t     idex, exmem, memwb;
    bit       cv, cz, e_stall, e_taken;
    bit [5:0] cop, cf;
    bit [4:0] crs, crt, crd;

    function automatic ins_t dec(bit v, bit [5:0] op, bit [5:0] f, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        ins_t d;
        bit   legal;
        d = '0;
        legal = 1'b1;
        if (!v) return d;
        case (op)
            OP_LW:  begin d.aluop = 4'd0; d.src = 1; d.mr = 1; d.m2r = 1; d.dst = rt; d.rw = (rt != 0); end
            OP_SW:  begin d.aluop = 4'd1; d.src = 1; d.mw = 1; end
            OP_R:   begin d.aluop = 4'd2; d.dst = rd; d.rw = (rd != 0); end
            OP_IMM: begin d.aluop = 4'd3; d.src = 1; d.dst = rt; d.rw = (rt != 0); end
            OP_BEQ: begin d.aluop = 4'd4; d.br = 1; end
            OP_J:   legal = 1'b0;
            default: begin d.ill = 1; legal = 1'b0; end
        endcase
        if (legal) begin d.funct = f; d.rs = rs; d.rt = rt; end
        return d;
    endfunction

    function automatic bit [1:0] fwd(bit [4:0] src);
        if (exmem.rw && exmem.dst != 0 && exmem.dst == src) return 2'b10;
        if (memwb.rw && memwb.dst != 0 && memwb.dst == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit [5:0] op, input bit [5:0] f,
                         input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd, input bit z);
        cv = v; cop = op; cf = f; crs = rs; crt = rt; crd = rd; cz = z;
        bus.id_valid = v; bus.id_op = op; bus.id_funct = f;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.ex_zero = z;
    endtask

    task automatic check_all();
        bit rrt, e_jump;
        rrt     = cv && (cop == OP_R || cop == OP_BEQ);
        e_taken = idex.br && cz;
        e_stall = !e_taken && idex.mr && idex.dst != 0 &&
                  (idex.dst == crs || (rrt && idex.dst == crt));
        e_jump  = !rst && !e_taken && !e_stall && cv && cop == OP_J;
        chk("pc_write", bus.pc_write, !e_stall);
        chk("if_id_write", bus.if_id_write, !e_stall);
        chk("if_id_flush", bus.if_id_flush, e_taken || e_jump);
        chk("id_jump", bus.id_jump, e_jump);
        chk("ex_branch_taken", bus.ex_branch_taken, e_taken);
        chk("ex_alu_op", bus.ex_alu_op, idex.aluop);
        chk("ex_alu_src", bus.ex_alu_src, idex.src);
        chk("ex_funct", bus.ex_funct, idex.funct);
        chk("ex_dst", bus.ex_dst, idex.dst);
        chk("fwd_a", bus.fwd_a, fwd(idex.rs));
        chk("fwd_b", bus.fwd_b, fwd(idex.rt));
        chk("mem_read", bus.mem_read, exmem.mr);
        chk("mem_write", bus.mem_write, exmem.mw);
        chk("wb_reg_write", bus.wb_reg_write, memwb.rw);
        chk("wb_mem_to_reg", bus.wb_mem_to_reg, memwb.m2r);
        chk("wb_dst", bus.wb_dst, memwb.dst);
        chk("illegal_op", bus.illegal_op, idex.ill);
    endtask

    task automatic step(input bit v, input bit [5:0] op, input bit [5:0] f,
                        input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd, input bit z);
        drive(v, op, f, rs, rt, rd, z);
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        ins_t nx;
        nx = (e_taken || e_stall) ? ins_t'('0) : dec(cv, cop, cf, crs, crt, crd);
        memwb = exmem;
        exmem = idex;
        idex  = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        drive(0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
        idex = '0; exmem = '0; memwb = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_pc_write", bus.pc_write, 1);
        rst = 1'b0;

        // streaming adds, then reset lands mid-flight
        step(1, OP_R, 6'h20, 5'd1, 5'd2, 5'd3, 0); adv();
        step(1, OP_R, 6'h20, 5'd1, 5'd2, 5'd4, 0); adv();
        step(1, OP_R, 6'h22, 5'd3, 5'd4, 5'd5, 0);
        #2 rst = 1'b1;
        #1 idex = '0; exmem = '0; memwb = '0;
        check_all();
        chk("midrst_wb_reg_write", bus.wb_reg_write, 0);
        chk("midrst_if_id_write", bus.if_id_write, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, OP_R, 6'h20, 5'd1, 5'd2, 5'd7, 0); adv();
        nop(); adv();
        nop(); adv();
        nop();
        chk("add_wb_reg_write", bus.wb_reg_write, 1);
        chk("add_wb_dst", bus.wb_dst, 7);
        adv();

        // load-use: one stall, then MEM/WB forwarding
        step(1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0, 0); adv();
        step(1, OP_R, 6'h20, 5'd2, 5'd4, 5'd3, 0);
        chk("lu_stall_pc", bus.pc_write, 0);
        adv();
        step(1, OP_R, 6'h20, 5'd2, 5'd4, 5'd3, 0);
        chk("lu_bubble_alu_op", bus.ex_alu_op, 0);
        chk("lu_pc_resume", bus.pc_write, 1);
        adv();
        nop();
        chk("lu_fwd_a", bus.fwd_a, 2'b01);
        adv();

        // EX/MEM forwarding, also when MEM/WB holds the same producer
        step(1, OP_R, 6'h20, 5'd1, 5'd1, 5'd5, 0); adv();
        step(1, OP_R, 6'h20, 5'd1, 5'd1, 5'd5, 0); adv();
        step(1, OP_R, 6'h22, 5'd5, 5'd5, 5'd6, 0);
        chk("fw_no_stall", bus.pc_write, 1);
        adv();
        nop();
        chk("fw_a_exmem", bus.fwd_a, 2'b10);
        chk("fw_b_exmem", bus.fwd_b, 2'b10);
        adv();

        // taken branch beats a jump in ID; untaken branch does nothing
        step(1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 0); adv();
        step(1, OP_J, 6'd0, 5'd0, 5'd0, 5'd0, 1);
        chk("br_taken", bus.ex_branch_taken, 1);
        chk("br_flush", bus.if_id_flush, 1);
        chk("br_no_jump", bus.id_jump, 0);
        adv();
        step(0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1);
        chk("br_bubble", bus.ex_branch_taken, 0);
        adv();
        step(1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 0); adv();
        step(1, OP_R, 6'h20, 5'd1, 5'd2, 5'd3, 0);
        chk("br_untaken_flush", bus.if_id_flush, 0);
        adv();

        // jump
        step(1, OP_J, 6'd0, 5'd0, 5'd0, 5'd0, 0);
        chk("j_id_jump", bus.id_jump, 1);
        chk("j_flush", bus.if_id_flush, 1);
        adv();
        nop();
        chk("j_ex_alu_op", bus.ex_alu_op, 0);
        chk("j_jump_gone", bus.id_jump, 0);
        adv();

        // illegal opcode, then a write to $0
        step(1, 6'h3f, 6'h15, 5'd1, 5'd2, 5'd3, 0); adv();
        step(1, OP_R, 6'h20, 5'd1, 5'd1, 5'd0, 0);
        chk("ill_pulse", bus.illegal_op, 1);
        adv();
        nop();
        chk("ill_pulse_end", bus.illegal_op, 0);
        adv();
        nop(); adv();
        nop();
        chk("r0_wb_reg_write", bus.wb_reg_write, 0);
        adv();

        // random traffic, IF/ID held while stalled
        for (int n = 0; n < 500; n++) begin
            bit [5:0] op;
            if (!e_stall) begin
                case ($urandom_range(0, 7))
                    0: op = OP_LW;
                    1: op = OP_SW;
                    2: op = OP_R;
                    3: op = OP_IMM;
                    4: op = OP_BEQ;
                    5: op = OP_J;
                    6: op = 6'h3f;
                    default: op = 6'($urandom);
                endcase
                step($urandom_range(0, 9) != 0, op, 6'($urandom), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
            end else begin
                step(cv, cop, cf, crs, crt, crd, 1'($urandom));
            end
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
